// File: rtl/load_store_unit.sv
// Load/store unit bridging a valid/ready CPU request port to a single-port
// RAM with a one-cycle registered read. One access is in flight at a time:
// IDLE accepts, ACCESS presents the address to the RAM, CAPTURE picks up load
// data, RESP holds the response until the CPU takes it.
module load_store_unit #(
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_store,
  input  logic [15:0]          req_addr,
  input  logic [DATA_BITS-1:0] req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [DATA_BITS-1:0] resp_rdata,
  output logic                 resp_err,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [DATA_BITS-1:0] ram_write_data,
  output logic                 ram_write_enable,
  input  logic [DATA_BITS-1:0] ram_read_data,
  output logic [15:0]          access_count
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

  state_t                 state_q, state_d;
  logic                   valid_q, valid_d;
  logic [DATA_BITS-1:0]   rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [DATA_BITS-1:0]   wdata_q, wdata_d;
  logic                   we_q, we_d;
  logic [15:0]            count_q, count_d;

  // Next-state and datapath register updates for the access sequence.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    count_d   = count_q;
    req_ready = (state_q == IDLE);
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          // Out-of-range upper bits only flag an error; the access still
          // goes ahead on the truncated address.
          addr_d  = req_addr[ADDR_BITS-1:0];
          wdata_d = req_wdata;
          we_d    = req_store;
          err_d   = |req_addr[15:ADDR_BITS];
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          we_d    = 1'b0;
          valid_d = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        rdata_d = ram_read_data;
        valid_d = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          valid_d = 1'b0;
          count_d = count_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and register bank with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      count_q <= count_d;
    end
  end

  // The write strobe is masked by reset so a store caught in ACCESS is not
  // committed by the RAM on the reset edge itself.
  assign ram_write_enable = we_q & rst_n;
  assign ram_addr         = addr_q;
  assign ram_write_data   = wdata_q;
  assign resp_valid       = valid_q;
  assign resp_rdata       = rdata_q;
  assign resp_err         = err_q;
  assign access_count     = count_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic [9:0]  ram_addr;
  logic [15:0] ram_write_data;
  logic        ram_write_enable;
  logic [15:0] ram_read_data;
  logic [15:0] access_count;

  int n_tests = 0;
  int n_fail  = 0;
  int we_cnt  = 0;

  typedef struct packed {
    logic [15:0] rdata;
    logic        err;
  } resp_t;
  resp_t exp_q[$];

  logic [15:0] mem [0:1023];

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_store        (req_store),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_rdata       (resp_rdata),
    .resp_err         (resp_err),
    .ram_addr         (ram_addr),
    .ram_write_data   (ram_write_data),
    .ram_write_enable (ram_write_enable),
    .ram_read_data    (ram_read_data),
    .access_count     (access_count)
  );

  // RAM model: Memory[i]=i, one-cycle registered read, read-before-write.
  initial for (int i = 0; i < 1024; i++) mem[i] = i[15:0];
  always @(posedge clk) begin
    if (ram_write_enable) mem[ram_addr] <= ram_write_data;
    ram_read_data <= mem[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a response is handed over.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 32'(resp_rdata), 32'hDEAD_0000);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        check("resp_rdata", 32'(resp_rdata), 32'(e.rdata));
        check("resp_err", 32'(resp_err), 32'(e.err));
      end
    end
  end

  // Write strobe high-cycle counter.
  always @(negedge clk) if (rst_n === 1'b1 && ram_write_enable === 1'b1) we_cnt++;

  // Wait (bounded) until the unit is back in IDLE; called at posedge+1.
  task automatic wait_idle();
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_timeout", 32'(req_ready), 32'd1);
  endtask

  // Issue one request, push its expected response and measure latency.
  task automatic do_req(input bit st, input logic [15:0] a, input logic [15:0] wd,
                        input logic [15:0] exp_rd, input bit exp_err, input int exp_lat);
    int lat;
    resp_t e;
    req_valid = 1'b1; req_store = st; req_addr = a; req_wdata = wd;
    e.rdata = exp_rd; e.err = exp_err;
    exp_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("ram_addr", 32'(ram_addr), 32'(a[9:0]));
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, exp_lat);
  endtask

  initial begin
    int w0;
    logic [15:0] exp_count;
    rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_access_count", 32'(access_count), 0);
    check("rst_req_ready", 32'(req_ready), 1);
    check("rst_we", 32'(ram_write_enable), 0);
    rst_n = 1'b1;
    exp_count = 16'd0;

    // Plain load.
    do_req(1'b0, 16'h0005, 16'h0000, 16'h0005, 1'b0, 2);
    wait_idle(); exp_count++;
    check("count_load5", 32'(access_count), 32'(exp_count));

    // Store then load back.
    w0 = we_cnt;
    do_req(1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, 1);
    wait_idle(); exp_count++;
    check("store_we_pulses", we_cnt - w0, 1);
    check("count_store", 32'(access_count), 32'(exp_count));
    w0 = we_cnt;
    do_req(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 2);
    wait_idle(); exp_count++;
    check("load_we_pulses", we_cnt - w0, 0);

    // Out-of-range address: truncated access plus error flag.
    do_req(1'b0, 16'h0407, 16'h0000, 16'h0007, 1'b1, 2);
    wait_idle(); exp_count++;
    check("count_err", 32'(access_count), 32'(exp_count));

    // Backpressure: response held, second request ignored.
    resp_ready = 1'b0;
    w0 = we_cnt;
    do_req(1'b0, 16'h0003, 16'h0000, 16'h0003, 1'b0, 2);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 32'(resp_valid), 1);
      check("hold_rdata", 32'(resp_rdata), 32'h0003);
      check("hold_req_ready", 32'(req_ready), 0);
      check("hold_ram_addr", 32'(ram_addr), 32'h003);
      if (i == 1) begin
        req_valid = 1'b1; req_store = 1'b1; req_addr = 16'h0055; req_wdata = 16'hAAAA;
      end
      @(posedge clk); #1;
    end
    check("hold_no_write", we_cnt - w0, 0);
    check("hold_count", 32'(access_count), 32'(exp_count));
    req_valid = 1'b0;
    resp_ready = 1'b1;
    wait_idle(); exp_count++;
    check("count_hold", 32'(access_count), 32'(exp_count));

    // Reset during the ACCESS cycle of a store.
    req_valid = 1'b1; req_store = 1'b1; req_addr = 16'h0020; req_wdata = 16'h1234;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_access_we", 32'(ram_write_enable), 0);
    @(posedge clk); #1;
    check("rst2_resp_valid", 32'(resp_valid), 0);
    check("rst2_resp_rdata", 32'(resp_rdata), 0);
    check("rst2_resp_err", 32'(resp_err), 0);
    check("rst2_ram_addr", 32'(ram_addr), 0);
    check("rst2_ram_wdata", 32'(ram_write_data), 0);
    check("rst2_we", 32'(ram_write_enable), 0);
    check("rst2_count", 32'(access_count), 0);
    rst_n = 1'b1;
    exp_count = 16'd0;
    #1;
    check("rst2_req_ready", 32'(req_ready), 1);
    do_req(1'b0, 16'h0020, 16'h0000, 16'h0020, 1'b0, 2);
    wait_idle(); exp_count++;
    check("count_after_rst", 32'(access_count), 32'(exp_count));

    // Counter wrap: preload near the top, then complete two accesses.
    force dut.count_q = 16'hFFFE;
    #1;
    release dut.count_q;
    exp_count = 16'hFFFE;
    do_req(1'b0, 16'h0001, 16'h0000, 16'h0001, 1'b0, 2);
    wait_idle(); exp_count++;
    check("count_ffff", 32'(access_count), 32'(exp_count));
    do_req(1'b1, 16'h0002, 16'h5A5A, 16'h0000, 1'b0, 1);
    wait_idle(); exp_count++;
    check("count_wrap", 32'(access_count), 32'h0000);

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
